// File: rtl/ctrl_wei_sched_pkg.sv
// Shared constants, state encoding and helpers for the weight-distribution scheduler.
package ctrl_wei_sched_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int BLOCK_DEPTH = 32;
    localparam int KERNEL_SIZE = 9;

    function automatic int C_LOG_2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int VAL_W    = C_LOG_2(BLOCK_DEPTH + 1);
    localparam int FLG_W    = BLOCK_DEPTH * KERNEL_SIZE;
    localparam int WEI_W    = DATA_WIDTH * FLG_W;
    localparam int WORD_W   = FLG_W + WEI_W;
    localparam int VALNUM_W = VAL_W * KERNEL_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RDREQ   = 3'd1,
        ST_WAITDAT = 3'd2,
        ST_CAPT    = 3'd3,
        ST_OFFER   = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

endpackage

// File: rtl/ctrl_wei_sched_if.sv
// DISWEI bus between the weight scheduler and the PEC array: per-PEC ready/get plus the shared block bus.
interface ctrl_wei_sched_if #(
    parameter int NUM_PEC = 16
);
    import ctrl_wei_sched_pkg::*;

    logic [NUM_PEC-1:0]  CTRLWEIPEC_RdyWei;
    logic [NUM_PEC-1:0]  PECCTRLWEI_GetWei;
    logic [WEI_W-1:0]    DISWEIPEC_Wei;
    logic [FLG_W-1:0]    DISWEIPEC_FlgWei;
    logic [VALNUM_W-1:0] DISWEIPEC_ValNumWei;

    modport master (
        output CTRLWEIPEC_RdyWei,
        output DISWEIPEC_Wei,
        output DISWEIPEC_FlgWei,
        output DISWEIPEC_ValNumWei,
        input  PECCTRLWEI_GetWei
    );

    modport slave (
        input  CTRLWEIPEC_RdyWei,
        input  DISWEIPEC_Wei,
        input  DISWEIPEC_FlgWei,
        input  DISWEIPEC_ValNumWei,
        output PECCTRLWEI_GetWei
    );

endinterface

// File: rtl/ctrl_wei_sched_wei_popcnt.sv
// Combinational nonzero count of one kernel slot's flag slice.
module wei_popcnt
    import ctrl_wei_sched_pkg::*;
(
    input  logic [BLOCK_DEPTH-1:0] flg,
    output logic [VAL_W-1:0]       cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < BLOCK_DEPTH; i++) begin
            cnt = cnt + VAL_W'(flg[i]);
        end
    end

endmodule

// File: rtl/ctrl_wei_sched.sv
// Weight scheduler: reads one compressed block per PEC from SRAM and offers it round-robin
// over the shared DISWEI bus, repeating for the configured number of block rounds.
module ctrl_wei_sched
    import ctrl_wei_sched_pkg::*;
#(
    parameter int NUM_PEC = 16,
    parameter int ADDR_W  = 12,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_blk,
    output logic              busy,
    output logic              done,
    output logic              SRAM_EnRd,
    output logic [ADDR_W-1:0] SRAM_AddrRd,
    input  logic [WORD_W-1:0] SRAM_DatRd,
    ctrl_wei_sched_if.master  pec_bus
);

    localparam int PW = (NUM_PEC > 1) ? C_LOG_2(NUM_PEC) : 1;
    localparam int LW = (RD_LAT > 1) ? C_LOG_2(RD_LAT) : 1;

    state_e              state_q, state_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [PW-1:0]       pec_q, pec_d;
    logic [15:0]         blk_q, blk_d;
    logic [15:0]         num_blk_q, num_blk_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_rd_q, en_rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_PEC-1:0]  rdy_q, rdy_d;
    logic [WEI_W-1:0]    wei_q, wei_d;
    logic [FLG_W-1:0]    flg_q, flg_d;
    logic [VALNUM_W-1:0] val_q, val_d;

    logic [VALNUM_W-1:0] pop_cnt;
    logic                get_hit;
    logic                last_pec;
    logic                last_blk;
    logic                capture;

    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_pop
        wei_popcnt u_pop (
            .flg (SRAM_DatRd[WEI_W + k*BLOCK_DEPTH +: BLOCK_DEPTH]),
            .cnt (pop_cnt[k*VAL_W +: VAL_W])
        );
    end

    assign get_hit  = (state_q == ST_OFFER) && pec_bus.PECCTRLWEI_GetWei[pec_q];
    assign last_pec = (pec_q == PW'(NUM_PEC - 1));
    assign last_blk = (blk_q == num_blk_q - 16'd1);

    // Blocks are stored contiguously per round, so the read address simply advances by one per handoff.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        pec_d     = pec_q;
        blk_d     = blk_q;
        num_blk_d = num_blk_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_num_blk == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d   = ST_RDREQ;
                            num_blk_d = cfg_num_blk;
                            addr_d    = cfg_base_addr;
                            pec_d     = '0;
                            blk_d     = '0;
                        end
                    end
                end
                ST_RDREQ: begin
                    state_d = ST_WAITDAT;
                    lat_d   = '0;
                end
                ST_WAITDAT: begin
                    if (lat_q == LW'(RD_LAT - 1)) begin
                        state_d = ST_CAPT;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                ST_CAPT: begin
                    state_d = ST_OFFER;
                end
                ST_OFFER: begin
                    if (get_hit) begin
                        if (last_pec && last_blk) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RDREQ;
                            addr_d  = addr_q + ADDR_W'(1);
                            if (last_pec) begin
                                pec_d = '0;
                                blk_d = blk_q + 16'd1;
                            end else begin
                                pec_d = pec_q + PW'(1);
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state; the bus only loads when leaving CAPT.
    always_comb begin
        en_rd_d = (state_d == ST_RDREQ);
        busy_d  = (state_d != ST_IDLE);
        for (int i = 0; i < NUM_PEC; i++) begin
            rdy_d[i] = (state_d == ST_OFFER) && (pec_d == PW'(i));
        end
        capture = (state_q == ST_CAPT) && !cfg_abort;
        wei_d   = capture ? SRAM_DatRd[WEI_W-1:0]      : wei_q;
        flg_d   = capture ? SRAM_DatRd[WORD_W-1:WEI_W] : flg_q;
        val_d   = capture ? pop_cnt                    : val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            pec_q     <= '0;
            blk_q     <= '0;
            num_blk_q <= '0;
            addr_q    <= '0;
            en_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= '0;
            wei_q     <= '0;
            flg_q     <= '0;
            val_q     <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            pec_q     <= pec_d;
            blk_q     <= blk_d;
            num_blk_q <= num_blk_d;
            addr_q    <= addr_d;
            en_rd_q   <= en_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
            wei_q     <= wei_d;
            flg_q     <= flg_d;
            val_q     <= val_d;
        end
    end

    assign busy                        = busy_q;
    assign done                        = done_q;
    assign SRAM_EnRd                   = en_rd_q;
    assign SRAM_AddrRd                 = addr_q;
    assign pec_bus.CTRLWEIPEC_RdyWei   = rdy_q;
    assign pec_bus.DISWEIPEC_Wei       = wei_q;
    assign pec_bus.DISWEIPEC_FlgWei    = flg_q;
    assign pec_bus.DISWEIPEC_ValNumWei = val_q;

endmodule

// File: tb/tb_ctrl_wei_sched.sv
// Self-checking bench for ctrl_wei_sched: SRAM model, PEC Get models and an expected-handoff scoreboard.
module tb_ctrl_wei_sched;
    import ctrl_wei_sched_pkg::*;

    localparam int NUM_PEC = 4;
    localparam int ADDR_W  = 12;
    localparam int RD_LAT  = 2;

    typedef struct packed {
        logic [1:0]  pec;
        logic [11:0] addr;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              cfg_start;
    logic              cfg_abort;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [15:0]       cfg_num_blk;
    logic              busy;
    logic              done;
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_W-1:0] sram_dat;

    ctrl_wei_sched_if #(.NUM_PEC(NUM_PEC)) pec_if ();

    ctrl_wei_sched #(
        .NUM_PEC (NUM_PEC),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_blk   (cfg_num_blk),
        .busy          (busy),
        .done          (done),
        .SRAM_EnRd     (sram_en),
        .SRAM_AddrRd   (sram_addr),
        .SRAM_DatRd    (sram_dat),
        .pec_bus       (pec_if)
    );

    exp_t       rd_q[$];
    exp_t       off_q[$];
    int         checks;
    int         errors;
    int         done_cnt;
    int         rd_cnt;
    int         min_gap;
    int         last_rd;
    int         cyc;
    int         get_delay[NUM_PEC];
    logic [3:0] spam_mask;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // SRAM contents are a pure function of address; 0x010 and 0x011 carry the popcount corner patterns.
    function automatic logic [WORD_W-1:0] sram_word(input logic [11:0] a);
        logic [WORD_W-1:0] w;
        logic [31:0]       s;
        w = '0;
        for (int i = 0; i < FLG_W; i++) begin
            w[i*DATA_WIDTH +: DATA_WIDTH] = 8'(32'(a) * 7 + 32'(i) * 13 + 1);
        end
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (a == 12'h010)      s = (k == 0) ? 32'hFFFF_FFFF : ((k == 1) ? 32'h0000_0001 : 32'h0);
            else if (a == 12'h011) s = 32'h0;
            else                   s = ((32'(a) + 32'd1) * 32'h9E37_79B1) ^ (32'(k) * 32'h0100_0193);
            w[WEI_W + k*BLOCK_DEPTH +: BLOCK_DEPTH] = s;
        end
        return w;
    endfunction

    function automatic logic [63:0] fold64(input logic [WEI_W-1:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < WEI_W / 64; i++) begin
            r = {r[62:0], r[63]} ^ v[i*64 +: 64];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_wei_fold(input logic [11:0] a);
        logic [WORD_W-1:0] w;
        w = sram_word(a);
        return fold64(w[WEI_W-1:0]);
    endfunction

    function automatic logic [63:0] exp_flg_fold(input logic [11:0] a);
        logic [WORD_W-1:0] w;
        w = sram_word(a);
        return fold64(WEI_W'(w[WORD_W-1:WEI_W]));
    endfunction

    function automatic logic [VALNUM_W-1:0] exp_valnum(input logic [11:0] a);
        logic [WORD_W-1:0]   w;
        logic [VALNUM_W-1:0] v;
        w = sram_word(a);
        v = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            v[k*VAL_W +: VAL_W] = VAL_W'($countones(w[WEI_W + k*BLOCK_DEPTH +: BLOCK_DEPTH]));
        end
        return v;
    endfunction

    // SRAM: read sampled on an edge, data appears RD_LAT cycles after the enable cycle and is held.
    initial begin
        logic        en_d1;
        logic        en_now;
        logic [11:0] a_d1;
        logic [11:0] a_now;
        en_d1    = 1'b0;
        a_d1     = '0;
        sram_dat = '0;
        forever begin
            @(posedge clk);
            en_now = sram_en;
            a_now  = sram_addr;
            #1;
            if (en_d1) sram_dat = sram_word(a_d1);
            en_d1 = en_now & rst_n;
            a_d1  = a_now;
        end
    end

    // PEC models: each waits get_delay cycles after seeing its Rdy, then pulses Get; spam_mask bits stay high.
    initial begin
        int         wait_cnt;
        int         idx;
        logic [3:0] g;
        wait_cnt = 0;
        pec_if.PECCTRLWEI_GetWei = '0;
        forever begin
            @(negedge clk);
            g   = spam_mask;
            idx = 0;
            if (pec_if.CTRLWEIPEC_RdyWei != '0) begin
                for (int i = 0; i < NUM_PEC; i++) if (pec_if.CTRLWEIPEC_RdyWei[i]) idx = i;
                if (wait_cnt >= get_delay[idx]) g = g | pec_if.CTRLWEIPEC_RdyWei;
                else wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
            pec_if.PECCTRLWEI_GetWei = g;
        end
    end

    // Monitor: checks every read address and every new offer against the scoreboard queues.
    initial begin
        exp_t       e;
        logic [3:0] prev_rdy;
        prev_rdy = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                checkOutput("rdy_onehot0", 64'($onehot0(pec_if.CTRLWEIPEC_RdyWei)), 64'd1);
                if (done) done_cnt++;
                if (sram_en) begin
                    rd_cnt++;
                    if (last_rd >= 0 && (cyc - last_rd) < min_gap) min_gap = cyc - last_rd;
                    last_rd = cyc;
                    if (rd_q.size() == 0) begin
                        checkOutput("unexpected_read", 64'(sram_addr), 64'hFFFF);
                    end else begin
                        e = rd_q.pop_front();
                        checkOutput("rd_addr", 64'(sram_addr), 64'(e.addr));
                    end
                end
                if (pec_if.CTRLWEIPEC_RdyWei != '0 && pec_if.CTRLWEIPEC_RdyWei != prev_rdy) begin
                    if (off_q.size() == 0) begin
                        checkOutput("unexpected_offer", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'd0);
                    end else begin
                        e = off_q.pop_front();
                        checkOutput("offer_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'(4'b0001 << e.pec));
                        checkOutput("offer_wei", fold64(pec_if.DISWEIPEC_Wei), exp_wei_fold(e.addr));
                        checkOutput("offer_flg", fold64(WEI_W'(pec_if.DISWEIPEC_FlgWei)), exp_flg_fold(e.addr));
                        checkOutput("offer_valnum", 64'(pec_if.DISWEIPEC_ValNumWei), 64'(exp_valnum(e.addr)));
                    end
                end
                prev_rdy = pec_if.CTRLWEIPEC_RdyWei;
            end else begin
                prev_rdy = '0;
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] base, input int nblk);
        exp_t e;
        for (int b = 0; b < nblk; b++) begin
            for (int p = 0; p < NUM_PEC; p++) begin
                e.pec  = 2'(p);
                e.addr = base + 12'(b * NUM_PEC + p);
                rd_q.push_back(e);
                off_q.push_back(e);
            end
        end
        cfg_base_addr = base;
        cfg_num_blk   = 16'(nblk);
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic waitRdy(input string tag, input logic [3:0] want, input int budget);
        int k;
        k = 0;
        while (pec_if.CTRLWEIPEC_RdyWei != want && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_rdy_seen"}, 64'(pec_if.CTRLWEIPEC_RdyWei), 64'(want));
    endtask

    task automatic checkQueuesEmpty(input string tag);
        checkOutput({tag, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        checkOutput({tag, "_off_left"}, 64'(off_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int rc;
        logic [VALNUM_W-1:0] v;
        checks = 0; errors = 0; done_cnt = 0; rd_cnt = 0; cyc = 0;
        min_gap = 1000; last_rd = -1;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_base_addr = '0; cfg_num_blk = '0; spam_mask = '0;
        for (int i = 0; i < NUM_PEC; i++) get_delay[i] = 1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_enrd", 64'(sram_en), 64'd0);
        checkOutput("rst_addr", 64'(sram_addr), 64'd0);
        checkOutput("rst_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'd0);
        checkOutput("rst_wei", fold64(pec_if.DISWEIPEC_Wei), 64'd0);
        checkOutput("rst_flg", fold64(WEI_W'(pec_if.DISWEIPEC_FlgWei)), 64'd0);
        checkOutput("rst_valnum", 64'(pec_if.DISWEIPEC_ValNumWei), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two rounds over four PECs from 0x010, popcount corners on the first block
        d0 = done_cnt;
        applyStimulus(12'h010, 2);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        waitRdy("t1", 4'b0001, 50);
        v = pec_if.DISWEIPEC_ValNumWei;
        checkOutput("pop_all_ones", 64'(v[0 +: VAL_W]), 64'd32);
        checkOutput("pop_single", 64'(v[VAL_W +: VAL_W]), 64'd1);
        checkOutput("pop_zero_rest", 64'(v[VALNUM_W-1:2*VAL_W]), 64'd0);
        waitDone("t1", 300);
        checkOutput("t1_done_count", 64'(done_cnt - d0), 64'd1);
        checkQueuesEmpty("t1");

        // PEC 2 stalls while the others hold Get high: offer to PEC 2 must be frozen
        for (int i = 0; i < NUM_PEC; i++) get_delay[i] = 0;
        get_delay[2] = 50;
        spam_mask = 4'b1011;
        min_gap = 1000; last_rd = -1;
        applyStimulus(12'h100, 1);
        waitRdy("t2", 4'b0100, 100);
        rc = rd_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("stall_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'h4);
            checkOutput("stall_wei", fold64(pec_if.DISWEIPEC_Wei), exp_wei_fold(12'h102));
        end
        checkOutput("stall_no_read", 64'(rd_cnt - rc), 64'd0);
        waitDone("t2", 300);
        checkOutput("min_period", 64'(min_gap), 64'(RD_LAT + 3));
        checkQueuesEmpty("t2");
        spam_mask = '0;
        for (int i = 0; i < NUM_PEC; i++) get_delay[i] = 1;

        // Abort in WAITDAT of block 1 PEC 1, then restart from base
        d0 = done_cnt;
        applyStimulus(12'h020, 2);
        begin
            int k;
            k = 0;
            while (!(sram_en && sram_addr == 12'h025) && k < 200) begin
                @(negedge clk);
                k++;
            end
            checkOutput("abort_read_seen", 64'(sram_addr), 64'h025);
        end
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'd0);
        checkOutput("abort_bus_hold", fold64(pec_if.DISWEIPEC_Wei), exp_wei_fold(12'h024));
        rd_q.delete();
        off_q.delete();
        rc = rd_cnt;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_done", 64'(done_cnt - d0), 64'd0);
        checkOutput("abort_no_read", 64'(rd_cnt - rc), 64'd0);
        applyStimulus(12'h020, 2);
        waitDone("t3", 300);
        checkOutput("t3_done_count", 64'(done_cnt - d0), 64'd1);
        checkQueuesEmpty("t3");

        // Start and abort together: abort wins
        rc = rd_cnt;
        cfg_base_addr = 12'h040; cfg_num_blk = 16'd1;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        checkOutput("both_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("both_no_read", 64'(rd_cnt - rc), 64'd0);

        // Zero rounds: immediate done, nothing read or offered
        rc = rd_cnt;
        applyStimulus(12'h050, 0);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("zero_done_pulse", 64'(done), 64'd0);
        checkOutput("zero_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("zero_no_read", 64'(rd_cnt - rc), 64'd0);

        // Address wrap from 0xFFE; a start mid-run with new config is ignored
        d0 = done_cnt;
        applyStimulus(12'hFFE, 1);
        repeat (8) @(negedge clk);
        checkOutput("wrap_busy_mid", 64'(busy), 64'd1);
        cfg_base_addr = 12'h555;
        cfg_num_blk   = 16'd7;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        waitDone("t5", 300);
        repeat (10) @(negedge clk);
        checkOutput("t5_done_count", 64'(done_cnt - d0), 64'd1);
        checkQueuesEmpty("t5");

        // Asynchronous reset during an offer
        applyStimulus(12'h030, 1);
        waitRdy("t6", 4'b0001, 50);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_rdy", 64'(pec_if.CTRLWEIPEC_RdyWei), 64'd0);
        checkOutput("arst_addr", 64'(sram_addr), 64'd0);
        checkOutput("arst_wei", fold64(pec_if.DISWEIPEC_Wei), 64'd0);
        checkOutput("arst_valnum", 64'(pec_if.DISWEIPEC_ValNumWei), 64'd0);
        rd_q.delete();
        off_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("arst_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
